// File: rtl/sum_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sum_streamer_if
//  Description : Run control, sum RAM read port and UART TX byte handshake
//                signals of the sum streamer. The master modport is the
//                streamer; the slave modport is its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface sum_streamer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 40
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    modport master (
        input  start, ram_rd_data, tx_busy,
        output busy, done, ram_rd_en, ram_rd_addr, tx_start, tx_data
    );

    modport slave (
        output start, ram_rd_data, tx_busy,
        input  busy, done, ram_rd_en, ram_rd_addr, tx_start, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/sum_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : sum_streamer
//  Description : Reads NUM_WORDS sum words from the sum RAM and sends each one
//                MSB byte first to the UART TX through a START/BUSY handshake.
//                Optional macro SUM_STREAM_CSUM_EN appends a modulo-256 sum of
//                all data bytes as one extra byte per run.
//  Revision    : 1.0  initial release
// ============================================================================
module sum_streamer #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 40,
    parameter int NUM_WORDS = 768,
    parameter int RD_LAT    = 2
) (
    input  logic           clk,
    input  logic           reset,      // asynchronous, active-low
    sum_streamer_if.master bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(RD_LAT - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_ACK   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   word_q,     word_d;
    logic [LAT_W-1:0]    lat_q,      lat_d;
    logic [BCNT_W-1:0]   byte_q,     byte_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic                rd_en_q,    rd_en_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_last_send;
`ifdef SUM_STREAM_CSUM_EN
    logic [7:0]          csum_q,     csum_d;
    logic                csum_ph_q,  csum_ph_d;
    logic [7:0]          w_csum_next;
`endif

    assign w_shifted = shift_q << 8;

`ifdef SUM_STREAM_CSUM_EN
    // the byte just acknowledged is still on tx_data_q, fold it in on DRAIN exit
    assign w_csum_next = csum_q + tx_data_q;
    assign w_last_send = csum_ph_q;
`else
    assign w_last_send = (byte_q == LAST_BYTE) && (word_q == LAST_WORD);
`endif

    // next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        lat_d      = lat_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        rd_en_d    = rd_en_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SUM_STREAM_CSUM_EN
        csum_d     = csum_q;
        csum_ph_d  = csum_ph_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    word_d  = '0;
                    lat_d   = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SUM_STREAM_CSUM_EN
                    csum_d    = 8'h00;
                    csum_ph_d = 1'b0;
`endif
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (lat_q == LAST_LAT) begin
                    rd_en_d = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_LOAD: begin
                shift_d    = bus.ram_rd_data;
                byte_d     = '0;
                tx_start_d = 1'b1;
                tx_data_d  = bus.ram_rd_data[DATA_W-1 -: 8];
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.tx_busy) begin
                    shift_d = w_shifted;
`ifdef SUM_STREAM_CSUM_EN
                    if (!csum_ph_q) csum_d = w_csum_next;
`endif
                    if (w_last_send) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (byte_q != LAST_BYTE) begin
                        byte_d     = byte_q + BCNT_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = w_shifted[DATA_W-1 -: 8];
                        state_d    = S_SEND;
                    end else if (word_q != LAST_WORD) begin
                        word_d  = word_q + ADDR_W'(1);
                        lat_d   = '0;
                        rd_en_d = 1'b1;
                        state_d = S_READ;
                    end
`ifdef SUM_STREAM_CSUM_EN
                    else begin
                        csum_ph_d  = 1'b1;
                        tx_start_d = 1'b1;
                        tx_data_d  = w_csum_next;
                        state_d    = S_SEND;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and output registers, cleared immediately on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            lat_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SUM_STREAM_CSUM_EN
            csum_q     <= 8'h00;
            csum_ph_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            lat_q      <= lat_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SUM_STREAM_CSUM_EN
            csum_q     <= csum_d;
            csum_ph_q  <= csum_ph_d;
`endif
        end
    end

    assign bus.ram_rd_en   = rd_en_q;
    assign bus.ram_rd_addr = word_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
`default_nettype wire
